// File: rtl/traffic_pkg.sv
// Shared types, default timing and config sanitising for the phase scheduler.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
// Contents: phase_t state codes, timing_t timing set, DEF_* reset constants,
//           sanitise() which makes a written timing set safe to run.
package traffic_pkg;

  // Width of every timing field and of the phase counter.
  localparam int TCW        = 8;
  localparam int DEF_ALLRED = 2;
  localparam int DEF_GMIN   = 10;
  localparam int DEF_GMAX   = 30;
  localparam int DEF_YEL    = 3;

  typedef enum logic [2:0] {
    PH_G1  = 3'd0,
    PH_Y1  = 3'd1,
    PH_AR1 = 3'd2,
    PH_G2  = 3'd3,
    PH_Y2  = 3'd4,
    PH_AR2 = 3'd5
  } phase_t;

  typedef struct packed {
    logic [TCW-1:0] gmin;
    logic [TCW-1:0] gmax;
    logic [TCW-1:0] yellow;
  } timing_t;

  // A zero gmin or yellow would make the compares never or always fire,
  // and gmax below gmin would be meaningless, so clamp them here.
  function automatic timing_t sanitise(input timing_t t);
    timing_t s;
    s.gmin   = (t.gmin == '0)   ? TCW'(1) : t.gmin;
    s.yellow = (t.yellow == '0) ? TCW'(1) : t.yellow;
    s.gmax   = (t.gmax < s.gmin) ? s.gmin : t.gmax;
    return s;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase counter: clears on request, otherwise counts up and saturates at all-ones.
// Latency: count registered on posedge; cnt_p1 and tc are combinational from it.
// Backpressure: none; free-running whenever not cleared.
// Ports: clk, rst (sync, active high), clr (restart at 0 next edge),
//        term (terminal count), cnt_p1 (count + 1, one bit wider), tc (cnt_p1 == term).
module phase_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [CW-1:0] term,
  output logic [CW:0]   cnt_p1,
  output logic          tc
);

  logic [CW-1:0] cnt;

  // One bit wider so cnt_p1 stays correct when cnt is saturated.
  assign cnt_p1 = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
  assign tc     = (cnt_p1 == {1'b0, term});

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt_p1[CW-1:0];
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-approach intersection phase scheduler: G1->Y1->AR1->G2->Y2->AR2 with demand arbitration.
// Latency: lamps and phase are a Moore decode of the state register, same cycle as state.
// Backpressure: cfg_ready is always 1; a config word is taken on every cfg_valid.
// Ports: clk, rst (sync, active high); cfg_valid/cfg_ready with cfg_gmin/cfg_gmax/cfg_yellow;
//        req1/req2 demand pulses; R1,Y1,G1,R2,Y2,G2 lamp drives; phase = state code.
// CW must equal traffic_pkg::TCW because the timing sets are stored as timing_t.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int CW       = TCW,
  parameter int ALLRED   = DEF_ALLRED,
  parameter int GMIN_DEF = DEF_GMIN,
  parameter int GMAX_DEF = DEF_GMAX,
  parameter int YEL_DEF  = DEF_YEL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_gmin,
  input  logic [CW-1:0] cfg_gmax,
  input  logic [CW-1:0] cfg_yellow,
  input  logic          req1,
  input  logic          req2,
  output logic          R1,
  output logic          Y1,
  output logic          G1,
  output logic          R2,
  output logic          Y2,
  output logic          G2,
  output logic [2:0]    phase
);

  localparam logic [CW-1:0] ALLRED_W = CW'(ALLRED);
  localparam timing_t       ACT_RST  = timing_t'{TCW'(GMIN_DEF), TCW'(GMAX_DEF), TCW'(YEL_DEF)};

  phase_t        state_q, state_d;
  timing_t       act_q, shd_q;
  logic          shd_vld_q;
  logic          pend1_q, pend2_q;
  logic [CW-1:0] term;
  logic [CW:0]   cnt_p1;
  logic          tc;
  logic          tmr_clr;
  logic          ge_min, ge_max;
  logic          go_g1, go_g2;
  logic          enter_g1, enter_g2;

  phase_timer #(.CW(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .term   (term),
    .cnt_p1 (cnt_p1),
    .tc     (tc)
  );

  assign ge_min = (cnt_p1 >= {1'b0, act_q.gmin});
  assign ge_max = (cnt_p1 >= {1'b0, act_q.gmax});

  // Leave green only with opposing demand; with none the block rests in green.
  assign go_g1 = (ge_min && pend2_q) || (ge_max && pend2_q);
  assign go_g2 = (ge_min && pend1_q) || (ge_max && pend1_q);

  assign tmr_clr  = (state_d != state_q);
  assign enter_g1 = (state_d == PH_G1) && (state_q != PH_G1);
  assign enter_g2 = (state_d == PH_G2) && (state_q != PH_G2);

  assign cfg_ready = 1'b1;
  assign phase     = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PH_AR2;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    term    = ALLRED_W;
    R1 = 1'b0; Y1 = 1'b0; G1 = 1'b0;
    R2 = 1'b0; Y2 = 1'b0; G2 = 1'b0;
    case (state_q)
      PH_G1: begin
        G1 = 1'b1; R2 = 1'b1;
        if (go_g1) state_d = PH_Y1;
      end
      PH_Y1: begin
        Y1 = 1'b1; R2 = 1'b1;
        term = act_q.yellow;
        if (tc) state_d = PH_AR1;
      end
      PH_AR1: begin
        R1 = 1'b1; R2 = 1'b1;
        if (tc) state_d = PH_G2;
      end
      PH_G2: begin
        R1 = 1'b1; G2 = 1'b1;
        if (go_g2) state_d = PH_Y2;
      end
      PH_Y2: begin
        R1 = 1'b1; Y2 = 1'b1;
        term = act_q.yellow;
        if (tc) state_d = PH_AR2;
      end
      PH_AR2: begin
        R1 = 1'b1; R2 = 1'b1;
        if (tc) state_d = PH_G1;
      end
      default: begin
        // Codes 6/7: show all-red and recover through AR2.
        R1 = 1'b1; R2 = 1'b1;
        state_d = PH_AR2;
      end
    endcase
  end

  // Demand latches: entry into an approach's green clears its own demand and
  // beats a request arriving on the same edge; requests during own green are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend1_q <= 1'b0;
      pend2_q <= 1'b0;
    end else begin
      if (enter_g1)                       pend1_q <= 1'b0;
      else if (req1 && state_q != PH_G1)  pend1_q <= 1'b1;
      if (enter_g2)                       pend2_q <= 1'b0;
      else if (req2 && state_q != PH_G2)  pend2_q <= 1'b1;
    end
  end

  // Config shadow: only the all-red to green boundary promotes it, so a phase
  // never changes timing underneath itself. A write on that same edge lands in
  // the shadow and waits for the next boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q     <= ACT_RST;
      shd_q     <= ACT_RST;
      shd_vld_q <= 1'b0;
    end else begin
      if ((enter_g1 || enter_g2) && shd_vld_q) begin
        act_q     <= sanitise(shd_q);
        shd_vld_q <= 1'b0;
      end
      if (cfg_valid) begin
        shd_q     <= timing_t'{cfg_gmin, cfg_gmax, cfg_yellow};
        shd_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: phase segments (code, length) scoreboarded.
// Latency: outputs sampled on the falling edge; inputs driven 1 time unit after posedge.
// Backpressure: n/a.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_gmin = '0, cfg_gmax = '0, cfg_yellow = '0;
  logic       req1 = 1'b0, req2 = 1'b0;
  logic       R1, Y1, G1, R2, Y2, G2;
  logic [2:0] phase;

  always #5 clk = ~clk;

  traffic_phase_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_gmin   (cfg_gmin),
    .cfg_gmax   (cfg_gmax),
    .cfg_yellow (cfg_yellow),
    .req1       (req1),
    .req2       (req2),
    .R1         (R1),
    .Y1         (Y1),
    .G1         (G1),
    .R2         (R2),
    .Y2         (Y2),
    .G2         (G2),
    .phase      (phase)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { logic [2:0] ph; int len; } seg_t;
  typedef struct { int scen; bit rst; bit r1; bit r2; bit cv;
                   logic [7:0] gmin; logic [7:0] gmax; logic [7:0] yel; int ncyc; } step_t;
  typedef struct { int scen; logic [2:0] ph; int len; } exp_t;

  seg_t  sb[$];
  step_t steps[$];
  exp_t  exps[$];

  logic [2:0] mon_cur = 3'd5;
  int         mon_run = 0;

  function automatic void check(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endfunction

  // Lamp vector {R1,Y1,G1,R2,Y2,G2} each phase code must show.
  function automatic int lamp_exp(input logic [2:0] ph);
    case (ph)
      3'd0:    return 6'b001_100;
      3'd1:    return 6'b010_100;
      3'd2:    return 6'b100_100;
      3'd3:    return 6'b100_001;
      3'd4:    return 6'b100_010;
      3'd5:    return 6'b100_100;
      default: return -1;
    endcase
  endfunction

  function automatic void seg_done(input logic [2:0] ph, input int len);
    seg_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL seg_extra got phase=%0d len=%0d want none", ph, len);
    end else begin
      e = sb.pop_front();
      check("seg_phase", int'(ph), int'(e.ph));
      check("seg_len", len, e.len);
    end
  endfunction

  // Run-length monitor: each completed phase run is compared with the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      mon_cur = 3'd5;
      mon_run = 0;
    end else begin
      check("lamps", int'({R1, Y1, G1, R2, Y2, G2}), lamp_exp(phase));
      if (phase == mon_cur) begin
        mon_run++;
      end else begin
        seg_done(mon_cur, mon_run);
        mon_cur = phase;
        mon_run = 1;
      end
    end
  end

  task automatic wait_cyc(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input bit r1v, input bit r2v);
    rst = 1'b1; req1 = 1'b0; req2 = 1'b0; cfg_valid = 1'b0;
    wait_cyc(2);
    check("rst_phase", int'(phase), 5);
    check("rst_lamps", int'({R1, Y1, G1, R2, Y2, G2}), 6'b100_100);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    rst = 1'b0; req1 = r1v; req2 = r2v;
  endtask

  task automatic push(input int ph, input int len);
    sb.push_back('{ph[2:0], len});
  endtask

  task automatic add_step(input int sc, input bit rs, input bit a, input bit b, input bit cv,
                          input int gmn, input int gmx, input int yl, input int n);
    steps.push_back('{sc, rs, a, b, cv, gmn[7:0], gmx[7:0], yl[7:0], n});
  endtask

  task automatic add_exp(input int sc, input int ph, input int len);
    exps.push_back('{sc, ph[2:0], len});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step_t st;

    // ---- stimulus table: scen, rst, req1, req2, cfg_valid, gmin, gmax, yellow, cycles
    // 1: req2 pulse at G1 cycle 3, later req1 pulse deep in G2.
    add_step(1, 1, 0, 0, 0, 0, 0, 0, 5);
    add_step(1, 0, 0, 1, 0, 0, 0, 0, 1);
    add_step(1, 0, 0, 0, 0, 0, 0, 0, 24);
    add_step(1, 0, 1, 0, 0, 0, 0, 0, 1);
    add_step(1, 0, 0, 0, 0, 0, 0, 0, 40);
    // 2: both requests held.
    add_step(2, 1, 1, 1, 0, 0, 0, 0, 70);
    // 3: config write mid-G1, then req1 held.
    add_step(3, 1, 0, 1, 0, 0, 0, 0, 5);
    add_step(3, 0, 1, 1, 1, 4, 6, 1, 1);
    add_step(3, 0, 1, 0, 0, 0, 0, 0, 40);
    // 4: all-zero config, both requests held.
    add_step(4, 1, 0, 0, 0, 0, 0, 0, 3);
    add_step(4, 0, 0, 1, 1, 0, 0, 0, 1);
    add_step(4, 0, 1, 1, 0, 0, 0, 0, 38);

    // ---- expected phase segments: scen, phase, length
    add_exp(1, 5, 2); add_exp(1, 0, 10); add_exp(1, 1, 3); add_exp(1, 2, 2);
    add_exp(1, 3, 15); add_exp(1, 4, 3); add_exp(1, 5, 2);
    add_exp(2, 5, 2);
    for (int k = 0; k < 2; k++) begin
      add_exp(2, 0, 10); add_exp(2, 1, 3); add_exp(2, 2, 2);
      add_exp(2, 3, 10); add_exp(2, 4, 3); add_exp(2, 5, 2);
    end
    add_exp(3, 5, 2); add_exp(3, 0, 10); add_exp(3, 1, 3); add_exp(3, 2, 2);
    add_exp(3, 3, 4); add_exp(3, 4, 1); add_exp(3, 5, 2);
    add_exp(4, 5, 2); add_exp(4, 0, 10); add_exp(4, 1, 3); add_exp(4, 2, 2);
    for (int k = 0; k < 3; k++) begin
      add_exp(4, 3, 1); add_exp(4, 4, 1); add_exp(4, 5, 2);
      add_exp(4, 0, 1); add_exp(4, 1, 1); add_exp(4, 2, 2);
    end

    // ---- rest in G1 with no demand, past counter saturation, then a late req2
    do_reset(1'b0, 1'b0);
    push(5, 2);
    wait_cyc(258);
    check("rest_phase", int'(phase), 0);
    check("rest_run", mon_run, 256);
    check("rest_G1", int'(G1), 1);
    check("rest_R2", int'(R2), 1);
    req2 = 1'b1;
    wait_cyc(1);
    req2 = 1'b0;
    push(0, 258); push(1, 3); push(2, 2);
    wait_cyc(20);
    check("rest_drain", sb.size(), 0);

    // ---- table-driven scenarios
    for (int i = 0; i < steps.size(); i++) begin
      st = steps[i];
      if (st.rst) begin
        check("scen_drain", sb.size(), 0);
        for (int k = 0; k < exps.size(); k++)
          if (exps[k].scen == st.scen) push(int'(exps[k].ph), exps[k].len);
        do_reset(st.r1, st.r2);
        wait_cyc(st.ncyc);
      end else begin
        req1 = st.r1; req2 = st.r2; cfg_valid = st.cv;
        cfg_gmin = st.gmin; cfg_gmax = st.gmax; cfg_yellow = st.yel;
        wait_cyc(1);
        cfg_valid = 1'b0;
        wait_cyc(st.ncyc - 1);
      end
    end
    check("scen_drain", sb.size(), 0);

    // ---- reset asserted during Y1
    do_reset(1'b0, 1'b1);
    push(5, 2); push(0, 10);
    wait_cyc(13);
    check("y1_reached", int'(phase), 1);
    check("y1_drain", sb.size(), 0);
    rst = 1'b1; req2 = 1'b0;
    wait_cyc(1);
    check("midrst_phase", int'(phase), 5);
    check("midrst_lamps", int'({R1, Y1, G1, R2, Y2, G2}), 6'b100_100);
    rst = 1'b0;
    push(5, 2);
    wait_cyc(30);
    check("midrst_drain", sb.size(), 0);
    check("midrst_phase_g1", int'(phase), 0);
    check("midrst_run", mon_run, 28);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

- Two-approach intersection phase scheduler.
- Sequences green/yellow/all-red phases for approach 1 and approach 2.
- Arbitrates between latched vehicle demand on each approach.
- Loads timing through a valid/ready config port; new values take effect only at phase boundaries.
- Drives the R1..G2 lamp outputs of the intersection top level.

## Interface
- CW, 8: width of timing fields and the phase counter.
- ALLRED, 2: all-red clearance length in cycles, minimum 1.
- GMIN_DEF, 10: reset value of active minimum green.
- GMAX_DEF, 30: reset value of active maximum green.
- YEL_DEF, 3: reset value of active yellow.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config word offered.
- cfg_ready  out  1  config accepted when high together with cfg_valid.
- cfg_gmin  in  CW  minimum green cycles.
- cfg_gmax  in  CW  maximum green cycles.
- cfg_yellow  in  CW  yellow cycles.
- req1, req2  in  1  demand pulses from approach 1 and approach 2 sensors.
- R1,Y1,G1,R2,Y2,G2  out  1 each  lamp drives, exactly one per approach high.
- phase  out  3  current state code.

## Operation
- States and codes: G1=0, Y1=1, AR1=2, G2=3, Y2=4, AR2=5. Codes 6 and 7 are illegal and recover to AR2.
- Fixed cycle order: G1 -> Y1 -> AR1 -> G2 -> Y2 -> AR2 -> G1.
- Lamps are a Moore decode of the state register:
  - G1 state: G1,R2 high. Y1 state: Y1,R2 high.
  - G2 state: R1,G2 high. Y2 state: R1,Y2 high.
  - AR1/AR2: R1,R2 high.
- cnt (CW bits) clears on every state change and otherwise increments, saturating at all-ones.
- Green dn (n = 1 or 2; m = the other approach) exits when either holds:
  - (cnt+1 >= gmin and pend_m), or
  - (cnt+1 >= gmax and pend_m).
  - With no opposing demand the block rests in green indefinitely.
  - pend_m is checked every cycle once gmin is met, so exit follows at the first cycle with cnt+1 >= gmin and pend_m.
- Yellow exits when cnt+1 == yellow. All-red exits when cnt+1 == ALLRED.
- Demand latches pend1, pend2:
  - reqn sets pendn.
  - pendn clears on the transition into Gn.
  - reqn in the same cycle as entry to Gn: clear wins.
  - reqn while in Gn: ignored.
- Config:
  - cfg_ready is constantly 1. On cfg_valid the three fields load a shadow set and a shadow_valid flag is set.
  - Shadow copies to the active set on each ARn -> G transition if shadow_valid, then shadow_valid clears.
  - A write in the same cycle as that transition goes to shadow only and applies at the next boundary.
- Sanitising on copy: a gmin or yellow of 0 becomes 1; gmax < gmin becomes gmin.
- Reset:
  - state=AR2, cnt=0, pend1=pend2=0, shadow_valid=0.
  - Active set = defaults.
  - Outputs: R1=R2=1, others 0, phase=5.
  - First green after reset is G1, after ALLRED cycles.
- Reset asserted mid-phase overrides everything on the next edge.

## Timing
- State register updates on posedge. Lamps and phase change in the same cycle as the state; no extra latency.
- Yellow lasts exactly yellow cycles; all-red lasts exactly ALLRED cycles.
- Green lasts between gmin and gmax cycles when opposing demand exists.
- Request-to-yellow latency in green with gmin met: the req edge sets pend; the next edge leaves green. That is 2 cycles from the req-high cycle to Yn visible.

## Structure
- Shared package traffic_pkg holds:
  - phase_t enum with codes above;
  - timing_t struct {gmin, gmax, yellow};
  - default constants.
- Sub-module phase_timer: counter with clear, saturation and terminal compare. Instantiated once.
- FSM, demand latches and config shadow live in the top.

## Test plan
- Reset release with default timing and no requests: AR2 for 2 cycles, then G1 held for 100 cycles. Lamps stay G1,R2; phase stays 0.
- req2 pulse at cycle 3 of G1, defaults: G1 lasts exactly 10 cycles, then Y1 for 3, AR1 for 2, then G2. pend2 clears on G2 entry.
- Both requests held high continuously, defaults: G1 and G2 each last 10 cycles, alternating with Y 3 and AR 2. Total cycle period 30.
- Config write mid-G1 (gmin=4, gmax=6, yellow=1): current G1/Y1 keep old timing. The next G2 uses the new set: with req1 held, G2 lasts 4 and Y2 lasts 1.
- Config gmin=0, gmax=0, yellow=0 applied: gmin=gmax=yellow=1. Green exits after 1 cycle under demand; yellow lasts 1.
- rst asserted during Y1: next edge gives phase=5, R1=R2=1 and pends cleared. After release, G1 follows in 2 cycles.
